vector_log_reader: RTL and testbench

- Reads back the simulation log format written by the exhaustive-vector benches: one ASCII line per vector, "<pattern bits> <response bits>\n".
- Accepts an ASCII byte stream (valid/ready), parses each line into a pattern/response record and emits it on a valid/ready record port.
- Checks that patterns arrive in exhaustive ascending order and flags completion of the full 2^N_BITS sweep.
- Sits between a log-file/byte source and the trojan-detection comparison logic.

---
 rtl/vlr_pkg.sv | 27 ++
 rtl/vector_log_reader_if.sv | 31 +++
 rtl/vector_log_reader_seq_check.sv | 36 +++
 rtl/vector_log_reader.sv | 170 +++++++++++++++++
 tb/tb_vector_log_reader.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vlr_pkg.sv
// Shared types and ASCII/error constants for the vector log reader.
package vlr_pkg;

  typedef enum logic [2:0] {
    S_PAT,
    S_SEP,
    S_RSP,
    S_EOL,
    S_SKIP
  } state_t;

  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_1  = 8'h31;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_CHAR  = 2'd1;
  localparam logic [1:0] ERR_FMT   = 2'd2;
  localparam logic [1:0] ERR_SHORT = 2'd3;

  function automatic logic is_digit(input logic [7:0] c);
    return (c == CH_0) || (c == CH_1);
  endfunction

endpackage

// File: rtl/vector_log_reader_if.sv
// Byte-stream input and parsed-record output of the vector log reader.
interface vector_log_reader_if #(
  parameter int N_BITS = 3,
  parameter int R_BITS = 1,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              rec_valid;
  logic              rec_ready;
  logic [N_BITS-1:0] rec_pattern;
  logic [R_BITS-1:0] rec_response;
  logic [CNT_W-1:0]  rec_index;
  logic              err_pulse;
  logic [1:0]        err_code;
  logic              seq_err;
  logic              sweep_done;

  modport slave (
    input  in_valid, in_byte, rec_ready,
    output in_ready, rec_valid, rec_pattern, rec_response, rec_index,
           err_pulse, err_code, seq_err, sweep_done
  );

  modport master (
    output in_valid, in_byte, rec_ready,
    input  in_ready, rec_valid, rec_pattern, rec_response, rec_index,
           err_pulse, err_code, seq_err, sweep_done
  );
endinterface

// File: rtl/vector_log_reader_seq_check.sv
// Tracks record index, ascending-order violations and full-sweep completion.
module vlr_seq_check #(
  parameter int N_BITS = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [N_BITS-1:0] pattern,
  output logic [CNT_W-1:0]  rec_index,
  output logic              seq_err,
  output logic              sweep_done
);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((64'd1 << N_BITS) - 64'd1);

  logic [N_BITS-1:0] expected;
  logic [CNT_W-1:0]  next_idx;

  // Expected follows the observed pattern so a single skip flags only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expected   <= '0;
      next_idx   <= '0;
      rec_index  <= '0;
      seq_err    <= 1'b0;
      sweep_done <= 1'b0;
    end else if (load) begin
      if (pattern != expected) seq_err <= 1'b1;
      expected  <= pattern + N_BITS'(1);
      rec_index <= next_idx;
      next_idx  <= next_idx + CNT_W'(1);
      if (next_idx == LAST_IDX) sweep_done <= 1'b1;
    end
  end

endmodule

// File: rtl/vector_log_reader.sv
// Parses "<pattern> <response>\n" ASCII lines into records with order checking.
module vector_log_reader
  import vlr_pkg::*;
#(
  parameter int N_BITS = 3,
  parameter int R_BITS = 1,
  parameter int CNT_W  = 16
) (
  input logic CK,
  input logic reset,
  vector_log_reader_if.slave bus
);
  localparam int unsigned MAXW = (N_BITS > R_BITS) ? N_BITS : R_BITS;
  localparam int unsigned BW   = $clog2(MAXW + 1);

  state_t            state, state_n;
  logic [N_BITS-1:0] pat_q, pat_n;
  logic [R_BITS-1:0] rsp_q, rsp_n;
  logic [BW-1:0]     cnt_q, cnt_n;
  logic              cr_q, cr_n;
  logic              accept, load, err_now, bit_in;
  logic [1:0]        err_val;

  logic              rec_valid_q;
  logic [N_BITS-1:0] rec_pattern_q;
  logic [R_BITS-1:0] rec_response_q;
  logic              err_pulse_q;
  logic [1:0]        err_code_q;

  assign bus.in_ready     = !rec_valid_q || bus.rec_ready;
  assign accept           = bus.in_valid && bus.in_ready;
  assign bit_in           = (bus.in_byte == CH_1);
  assign bus.rec_valid    = rec_valid_q;
  assign bus.rec_pattern  = rec_pattern_q;
  assign bus.rec_response = rec_response_q;
  assign bus.err_pulse    = err_pulse_q;
  assign bus.err_code     = err_code_q;

  always_comb begin
    state_n = state;
    pat_n   = pat_q;
    rsp_n   = rsp_q;
    cnt_n   = cnt_q;
    cr_n    = cr_q;
    load    = 1'b0;
    err_now = 1'b0;
    err_val = ERR_NONE;
    if (accept) begin
      unique case (state)
        S_PAT: begin
          if (is_digit(bus.in_byte)) begin
            pat_n = N_BITS'({pat_q, bit_in});
            cnt_n = cnt_q + BW'(1);
            if (cnt_q == BW'(N_BITS - 1)) begin
              state_n = S_SEP;
              cnt_n   = '0;
            end
          end else if (bus.in_byte == CH_LF) begin
            if (cnt_q != '0) begin
              err_now = 1'b1;
              err_val = ERR_SHORT;
            end
          end else begin
            err_now = 1'b1;
            err_val = ERR_CHAR;
            state_n = S_SKIP;
          end
        end
        S_SEP: begin
          if (bus.in_byte == CH_SP) begin
            state_n = S_RSP;
          end else if (bus.in_byte == CH_LF) begin
            err_now = 1'b1;
            err_val = ERR_SHORT;
            state_n = S_PAT;
          end else begin
            err_now = 1'b1;
            err_val = ERR_FMT;
            state_n = S_SKIP;
          end
        end
        S_RSP: begin
          if (is_digit(bus.in_byte)) begin
            rsp_n = R_BITS'({rsp_q, bit_in});
            cnt_n = cnt_q + BW'(1);
            if (cnt_q == BW'(R_BITS - 1)) begin
              state_n = S_EOL;
              cnt_n   = '0;
            end
          end else if (bus.in_byte == CH_LF) begin
            err_now = 1'b1;
            err_val = ERR_SHORT;
            state_n = S_PAT;
          end else begin
            err_now = 1'b1;
            err_val = ERR_CHAR;
            state_n = S_SKIP;
          end
        end
        S_EOL: begin
          if (bus.in_byte == CH_CR && !cr_q) begin
            cr_n = 1'b1;
          end else if (bus.in_byte == CH_LF) begin
            load    = 1'b1;
            state_n = S_PAT;
          end else begin
            err_now = 1'b1;
            err_val = ERR_FMT;
            state_n = S_SKIP;
          end
        end
        S_SKIP: begin
          if (bus.in_byte == CH_LF) state_n = S_PAT;
        end
        default: state_n = S_PAT;
      endcase
      // The output registers load from pat_q/rsp_q, so clearing here is safe.
      if (err_now || load) begin
        pat_n = '0;
        rsp_n = '0;
        cnt_n = '0;
        cr_n  = 1'b0;
      end
    end
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state          <= S_PAT;
      pat_q          <= '0;
      rsp_q          <= '0;
      cnt_q          <= '0;
      cr_q           <= 1'b0;
      rec_valid_q    <= 1'b0;
      rec_pattern_q  <= '0;
      rec_response_q <= '0;
      err_pulse_q    <= 1'b0;
      err_code_q     <= ERR_NONE;
    end else begin
      state       <= state_n;
      pat_q       <= pat_n;
      rsp_q       <= rsp_n;
      cnt_q       <= cnt_n;
      cr_q        <= cr_n;
      err_pulse_q <= err_now;
      if (err_now) err_code_q <= err_val;
      if (load) begin
        rec_valid_q    <= 1'b1;
        rec_pattern_q  <= pat_q;
        rec_response_q <= rsp_q;
      end else if (bus.rec_ready) begin
        rec_valid_q <= 1'b0;
      end
    end
  end

  vlr_seq_check #(
    .N_BITS(N_BITS),
    .CNT_W (CNT_W)
  ) u_seq_check (
    .clk       (CK),
    .rst       (reset),
    .load      (load),
    .pattern   (pat_q),
    .rec_index (bus.rec_index),
    .seq_err   (bus.seq_err),
    .sweep_done(bus.sweep_done)
  );

endmodule

// File: tb/tb_vector_log_reader.sv
// Self-checking bench for vector_log_reader: line table plus corner-case sequences.
module tb_vector_log_reader;
  import vlr_pkg::*;

  localparam int N_BITS = 3;
  localparam int R_BITS = 1;
  localparam int CNT_W  = 16;

  logic CK = 1'b0;
  logic reset;
  always #5 CK = ~CK;

  vector_log_reader_if #(.N_BITS(N_BITS), .R_BITS(R_BITS), .CNT_W(CNT_W)) bus ();

  vector_log_reader #(.N_BITS(N_BITS), .R_BITS(R_BITS), .CNT_W(CNT_W)) dut (
    .CK   (CK),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [2:0]  pat;
    logic        rsp;
    logic [15:0] idx;
  } exp_t;

  typedef struct {
    string      line;
    bit         has_rec;
    logic [2:0] pat;
    logic       rsp;
    logic [1:0] err;
    bit         sweep;
  } vec_t;

  exp_t        sb[$];
  vec_t        tbl[20];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          err_seen = 0;
  int          accepted = 0;
  int          exp_idx = 0;
  logic [2:0]  exp_next = '0;
  logic        exp_seq = 1'b0;
  logic [1:0]  exp_code = ERR_NONE;
  bit          bp_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic void push_rec(input logic [2:0] p, input logic r);
    exp_t e;
    e.pat = p;
    e.rsp = r;
    e.idx = exp_idx[15:0];
    sb.push_back(e);
    if (p != exp_next) exp_seq = 1'b1;
    exp_next = p + 3'd1;
    exp_idx++;
  endfunction

  // Scoreboard side: sample mid-cycle, just before the edge that transfers.
  initial begin
    exp_t e;
    forever begin
      @(negedge CK);
      #3;
      if (reset === 1'b0) begin
        if (bus.err_pulse === 1'b1) err_seen++;
        if (bus.rec_valid === 1'b1 && bus.rec_ready === 1'b1) begin
          if (sb.size() == 0) begin
            check("rec_spurious", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            check("rec_pattern", 32'(bus.rec_pattern), 32'(e.pat));
            check("rec_response", 32'(bus.rec_response), 32'(e.rsp));
            check("rec_index", 32'(bus.rec_index), 32'(e.idx));
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int  n = 0;
    bit  done = 1'b0;
    @(negedge CK);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    while (!done) begin
      #1;
      if (bus.in_ready === 1'b1) begin
        @(posedge CK);
        accepted++;
        done = 1'b1;
      end else begin
        n++;
        if (n > 200) begin
          check("in_ready_timeout", 32'd0, 32'd1);
          done = 1'b1;
        end else begin
          @(negedge CK);
        end
      end
    end
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CK);
  endtask

  task automatic do_reset();
    @(negedge CK);
    reset = 1'b1;
    #2;
    check("rst_rec_valid", 32'(bus.rec_valid), 32'd0);
    check("rst_err_pulse", 32'(bus.err_pulse), 32'd0);
    check("rst_err_code", 32'(bus.err_code), 32'd0);
    check("rst_seq_err", 32'(bus.seq_err), 32'd0);
    check("rst_sweep_done", 32'(bus.sweep_done), 32'd0);
    check("rst_rec_pattern", 32'(bus.rec_pattern), 32'd0);
    check("rst_rec_response", 32'(bus.rec_response), 32'd0);
    check("rst_rec_index", 32'(bus.rec_index), 32'd0);
    @(negedge CK);
    reset    = 1'b0;
    sb.delete();
    exp_idx  = 0;
    exp_next = '0;
    exp_seq  = 1'b0;
    exp_code = ERR_NONE;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int a0;
    int n;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_byte   = '0;
    bus.rec_ready = 1'b1;

    tbl[0]  = '{"000 0\n", 1'b1, 3'd0, 1'b0, ERR_NONE, 1'b0};
    tbl[1]  = '{"001 1\n", 1'b1, 3'd1, 1'b1, ERR_NONE, 1'b0};
    tbl[2]  = '{"010 1\n", 1'b1, 3'd2, 1'b1, ERR_NONE, 1'b0};
    tbl[3]  = '{"011 0\n", 1'b1, 3'd3, 1'b0, ERR_NONE, 1'b0};
    tbl[4]  = '{"100 1\n", 1'b1, 3'd4, 1'b1, ERR_NONE, 1'b0};
    tbl[5]  = '{"101 0\n", 1'b1, 3'd5, 1'b0, ERR_NONE, 1'b0};
    tbl[6]  = '{"110 0\n", 1'b1, 3'd6, 1'b0, ERR_NONE, 1'b0};
    tbl[7]  = '{"111 1\n", 1'b1, 3'd7, 1'b1, ERR_NONE, 1'b1};
    tbl[8]  = '{"0a1 0\n", 1'b0, 3'd0, 1'b0, ERR_CHAR, 1'b0};
    tbl[9]  = '{"010 1\n", 1'b1, 3'd2, 1'b1, ERR_NONE, 1'b0};
    tbl[10] = '{"01\n", 1'b0, 3'd0, 1'b0, ERR_SHORT, 1'b0};
    tbl[11] = '{"0111 0\n", 1'b0, 3'd0, 1'b0, ERR_FMT, 1'b0};
    tbl[12] = '{"101 1\015\n", 1'b1, 3'd5, 1'b1, ERR_NONE, 1'b0};
    tbl[13] = '{"\n", 1'b0, 3'd0, 1'b0, ERR_NONE, 1'b0};
    tbl[14] = '{"110 0\015\015\n", 1'b0, 3'd0, 1'b0, ERR_FMT, 1'b0};
    tbl[15] = '{"011 1 \n", 1'b0, 3'd0, 1'b0, ERR_FMT, 1'b0};
    tbl[16] = '{"000 x\n", 1'b0, 3'd0, 1'b0, ERR_CHAR, 1'b0};
    tbl[17] = '{"000\n", 1'b0, 3'd0, 1'b0, ERR_SHORT, 1'b0};
    tbl[18] = '{"001 \n", 1'b0, 3'd0, 1'b0, ERR_SHORT, 1'b0};
    tbl[19] = '{"11 0\n", 1'b0, 3'd0, 1'b0, ERR_CHAR, 1'b0};

    do_reset();

    for (int i = 0; i < 20; i++) begin
      if (i == 8) do_reset();
      e0 = err_seen;
      if (tbl[i].has_rec) push_rec(tbl[i].pat, tbl[i].rsp);
      send_line(tbl[i].line);
      idle(3);
      if (tbl[i].err != ERR_NONE) exp_code = tbl[i].err;
      check("err_pulses", 32'(err_seen - e0), (tbl[i].err != ERR_NONE) ? 32'd1 : 32'd0);
      check("err_code", 32'(bus.err_code), 32'(exp_code));
      check("sweep_done", 32'(bus.sweep_done), 32'(tbl[i].sweep));
      check("seq_err", 32'(bus.seq_err), 32'(exp_seq));
      check("sb_drained", 32'(sb.size()), 32'd0);
    end

    // Out-of-order pattern sets seq_err only on the offending record.
    do_reset();
    push_rec(3'd0, 1'b0);
    send_line("000 0\n");
    push_rec(3'd1, 1'b0);
    send_line("001 0\n");
    idle(3);
    check("seq_ok", 32'(bus.seq_err), 32'(exp_seq));
    push_rec(3'd0, 1'b0);
    send_line("000 0\n");
    idle(3);
    check("seq_bad", 32'(bus.seq_err), 32'd1);
    check("seq_model", 32'(bus.seq_err), 32'(exp_seq));

    // Reset with an error latched and a partial line in flight.
    send_line("1x\n");
    send_line("11");
    idle(2);
    check("pre_rst_err_code", 32'(bus.err_code), 32'(ERR_CHAR));
    do_reset();
    e0 = err_seen;
    push_rec(3'd0, 1'b1);
    send_line("000 1\n");
    idle(3);
    check("post_rst_no_err", 32'(err_seen - e0), 32'd0);
    check("post_rst_seq", 32'(bus.seq_err), 32'd0);
    check("post_rst_drained", 32'(sb.size()), 32'd0);

    // Backpressure: first record must hold and the parser must stall.
    @(negedge CK);
    bus.rec_ready = 1'b0;
    push_rec(3'd4, 1'b0);
    push_rec(3'd5, 1'b1);
    a0 = accepted;
    bp_done = 1'b0;
    fork
      begin
        send_line("100 0\n");
        send_line("101 1\n");
        bp_done = 1'b1;
      end
    join_none
    n = 0;
    while (bus.rec_valid !== 1'b1 && n < 100) begin
      @(negedge CK);
      n++;
    end
    check("bp_rec_valid", 32'(bus.rec_valid), 32'd1);
    idle(10);
    #1;
    check("bp_hold_valid", 32'(bus.rec_valid), 32'd1);
    check("bp_hold_pattern", 32'(bus.rec_pattern), 32'd4);
    check("bp_hold_response", 32'(bus.rec_response), 32'd0);
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp_bytes_stalled", 32'(accepted - a0), 32'd6);
    @(negedge CK);
    bus.rec_ready = 1'b1;
    n = 0;
    while (!bp_done && n < 200) begin
      @(negedge CK);
      n++;
    end
    check("bp_driver_done", 32'(bp_done), 32'd1);
    idle(3);
    check("bp_bytes_total", 32'(accepted - a0), 32'd12);
    check("bp_drained", 32'(sb.size()), 32'd0);
    check("bp_rec_valid_low", 32'(bus.rec_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
